// File: rtl/btn_event_in_pkg.sv
// Shared constants and helpers for the push-button event input path.
// Event payload layout is {flag, index}: flag (1 = press) at the MSB, button index below.
package btn_event_in_pkg;

  localparam int unsigned CLK_HZ                  = 25_000_000;
  localparam int unsigned DEBOUNCE_MS             = 10;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  typedef enum logic {
    EvtRelease = 1'b0,
    EvtPress   = 1'b1
  } evt_kind_e;

  // Width of a button index; never below 1 so a single-button build still has a field.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: polarity fix, 2-flop synchronizer, counter debounce and
// single-cycle press/release pulses issued together with the stable-level change.
module btn_debounce_chan
  import btn_event_in_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          INVERT          = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_state,
  output logic o_pressed,
  output logic o_released
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pressed;
  logic             r_released;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_cnt      <= '0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
    end else begin
      r_sync1    <= i_btn ^ INVERT;
      r_sync2    <= r_sync1;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      // Any return to the stable level wipes the accumulated count.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable   <= r_sync2;
        r_cnt      <= '0;
        r_pressed  <= r_sync2;
        r_released <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_state    = r_stable;
  assign o_pressed  = r_pressed;
  assign o_released = r_released;

endmodule

// File: rtl/btn_event_in.sv
// Board push-button input path: per-channel debounce, one pending slot per channel,
// lowest-index-first arbiter and a valid/ready event FIFO towards the core logic.
module btn_event_in
  import btn_event_in_pkg::*;
#(
  parameter int unsigned          NUM_BTNS        = 7,
  parameter int unsigned          DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [NUM_BTNS-1:0]  INVERT_MASK     = 7'b0000001,
  parameter int unsigned          FIFO_DEPTH      = 4,
  localparam int unsigned         IDX_W           = idx_w(NUM_BTNS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] io_btns,
  output logic [NUM_BTNS-1:0] io_state,
  output logic [NUM_BTNS-1:0] io_pressed,
  output logic [NUM_BTNS-1:0] io_released,
  output logic                io_evt_valid,
  input  logic                io_evt_ready,
  output logic [IDX_W:0]      io_evt_payload,
  output logic                io_overflow
);

  localparam int unsigned EVT_W = IDX_W + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [NUM_BTNS-1:0] w_pressed;
  logic [NUM_BTNS-1:0] w_released;
  logic [NUM_BTNS-1:0] w_pulse;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (INVERT_MASK[g])
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .i_btn     (io_btns[g]),
      .o_state   (io_state[g]),
      .o_pressed (w_pressed[g]),
      .o_released(w_released[g])
    );
  end

  assign w_pulse     = w_pressed | w_released;
  assign io_pressed  = w_pressed;
  assign io_released = w_released;

  logic [NUM_BTNS-1:0] r_pend;
  logic [NUM_BTNS-1:0] r_flag;
  logic                r_overflow;

  logic [EVT_W-1:0]    r_buf [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_can_push;
  logic [NUM_BTNS-1:0] w_grant;
  logic [NUM_BTNS-1:0] w_push_oh;
  logic                w_push;
  logic                w_pop;
  logic [IDX_W-1:0]    w_sel;
  logic                w_sel_flag;

  // Push decision uses the count at the start of the cycle; a same-cycle pop does not help.
  assign w_can_push = (r_count < CNT_W'(FIFO_DEPTH));
  assign w_grant    = r_pend & (~r_pend + 1'b1);
  assign w_push_oh  = w_can_push ? w_grant : '0;
  assign w_push     = |w_push_oh;
  assign w_pop      = (r_count != '0) && io_evt_ready;

  always_comb begin
    w_sel      = '0;
    w_sel_flag = 1'b0;
    for (int i = 0; i < int'(NUM_BTNS); i++) begin
      if (w_push_oh[i]) begin
        w_sel      = IDX_W'(i);
        w_sel_flag = r_flag[i];
      end
    end
  end

  // A new pulse always wins over the clearing push; it only counts as a loss if
  // the previous event in the slot was not taken this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend     <= '0;
      r_flag     <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_BTNS); i++) begin
        if (w_pulse[i]) begin
          r_pend[i] <= 1'b1;
          r_flag[i] <= w_pressed[i];
          if (r_pend[i] && !w_push_oh[i]) begin
            r_overflow <= 1'b1;
          end
        end else if (w_push_oh[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_buf[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_wptr] <= {w_sel_flag, w_sel};
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign io_evt_valid   = (r_count != '0);
  assign io_evt_payload = r_buf[r_rptr];
  assign io_overflow    = r_overflow;

endmodule

// File: tb/tb_btn_event_in.sv
// Directed bench for btn_event_in with an 8-cycle debounce and a 4-entry event queue.
module tb_btn_event_in;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] io_btns;
  logic [6:0] io_state;
  logic [6:0] io_pressed;
  logic [6:0] io_released;
  logic       io_evt_valid;
  logic       io_evt_ready;
  logic [3:0] io_evt_payload;
  logic       io_overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  btn_event_in #(
    .NUM_BTNS       (7),
    .DEBOUNCE_CYCLES(8),
    .INVERT_MASK    (7'b0000001),
    .FIFO_DEPTH     (4)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .io_btns       (io_btns),
    .io_state      (io_state),
    .io_pressed    (io_pressed),
    .io_released   (io_released),
    .io_evt_valid  (io_evt_valid),
    .io_evt_ready  (io_evt_ready),
    .io_evt_payload(io_evt_payload),
    .io_overflow   (io_overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count clocks until the given channel pulses; returns budget if it never does.
  task automatic wait_pulse(input int idx, input bit rel, input int budget, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!(rel ? io_released[idx] : io_pressed[idx]) && n < budget);
  endtask

  int n;
  int n_bounce;

  initial begin
    reset        = 1'b1;
    io_btns      = 7'b0000001;
    io_evt_ready = 1'b0;
    tick(3);
    check_eq("rst_state",    32'(io_state),       32'h0);
    check_eq("rst_pressed",  32'(io_pressed),     32'h0);
    check_eq("rst_released", 32'(io_released),    32'h0);
    check_eq("rst_valid",    32'(io_evt_valid),   32'h0);
    check_eq("rst_payload",  32'(io_evt_payload), 32'h0);
    check_eq("rst_overflow", 32'(io_overflow),    32'h0);
    reset = 1'b0;
    tick(20);
    check_eq("idle_inv_valid", 32'(io_evt_valid), 32'h0);
    check_eq("idle_inv_state", 32'(io_state),     32'h0);

    // Clean press on btn3
    io_btns[3] = 1'b1;
    tick(9);
    check_eq("press3_early", 32'(io_state[3]), 32'h0);
    tick(1);
    check_eq("press3_state", 32'(io_state),   32'h08);
    check_eq("press3_pulse", 32'(io_pressed), 32'h08);
    tick(1);
    check_eq("press3_pulse_end", 32'(io_pressed),   32'h0);
    check_eq("press3_not_yet",   32'(io_evt_valid), 32'h0);
    tick(1);
    check_eq("press3_valid",   32'(io_evt_valid),   32'h1);
    check_eq("press3_payload", 32'(io_evt_payload), 32'hB);
    io_evt_ready = 1'b1;
    tick(1);
    check_eq("press3_popped", 32'(io_evt_valid), 32'h0);
    io_evt_ready = 1'b0;

    // Bouncing btn2, then a clean final edge
    n_bounce = 0;
    for (int t = 0; t < 30; t++) begin
      if (t % 3 == 0) io_btns[2] = ~io_btns[2];
      tick(1);
      if (io_pressed[2] || io_released[2]) n_bounce++;
    end
    check_eq("bounce_quiet", 32'(n_bounce), 32'h0);
    io_btns[2] = 1'b1;
    wait_pulse(2, 1'b0, 20, n);
    check_eq("bounce_latency", 32'(n), 32'd10);
    tick(2);
    check_eq("bounce_valid",   32'(io_evt_valid),   32'h1);
    check_eq("bounce_payload", 32'(io_evt_payload), 32'hA);
    io_evt_ready = 1'b1;
    tick(1);
    io_evt_ready = 1'b0;
    n_bounce = 0;
    for (int t = 0; t < 10; t++) begin
      tick(1);
      if (io_pressed[2] || io_released[2]) n_bounce++;
    end
    check_eq("bounce_single", 32'(n_bounce), 32'h0);

    // Active-low btn0 pressed by driving the pin low
    io_btns[0] = 1'b0;
    wait_pulse(0, 1'b0, 20, n);
    check_eq("inv_latency", 32'(n), 32'd10);
    tick(2);
    check_eq("inv_valid",   32'(io_evt_valid),   32'h1);
    check_eq("inv_payload", 32'(io_evt_payload), 32'h8);
    io_evt_ready = 1'b1;
    tick(1);
    io_evt_ready = 1'b0;

    // Simultaneous presses drain lowest index first on consecutive cycles
    io_evt_ready = 1'b1;
    io_btns[1]   = 1'b1;
    io_btns[5]   = 1'b1;
    tick(10);
    check_eq("simul_pulse", 32'(io_pressed), 32'h22);
    tick(2);
    check_eq("simul_first_v", 32'(io_evt_valid),   32'h1);
    check_eq("simul_first",   32'(io_evt_payload), 32'h9);
    tick(1);
    check_eq("simul_second_v", 32'(io_evt_valid),   32'h1);
    check_eq("simul_second",   32'(io_evt_payload), 32'hD);
    tick(1);
    check_eq("simul_empty",    32'(io_evt_valid), 32'h0);
    check_eq("simul_overflow", 32'(io_overflow),  32'h0);
    io_evt_ready = 1'b0;

    // Full queue, btn4 held pending, then overwritten by its release
    reset   = 1'b1;
    io_btns = 7'b0000001;
    tick(2);
    reset = 1'b0;
    tick(3);
    io_btns = 7'b0011110;
    tick(10);
    check_eq("full_pulses", 32'(io_pressed), 32'h1F);
    tick(5);
    check_eq("full_valid",    32'(io_evt_valid),   32'h1);
    check_eq("full_head",     32'(io_evt_payload), 32'h8);
    check_eq("full_no_ovf",   32'(io_overflow),    32'h0);
    io_btns = 7'b0001110;
    wait_pulse(4, 1'b1, 20, n);
    check_eq("rel4_latency", 32'(n), 32'd10);
    tick(1);
    check_eq("ovf_set", 32'(io_overflow), 32'h1);
    io_evt_ready = 1'b1;
    check_eq("drain0", 32'(io_evt_payload), 32'h8);
    tick(1);
    check_eq("drain1", 32'(io_evt_payload), 32'h9);
    tick(1);
    check_eq("drain2", 32'(io_evt_payload), 32'hA);
    tick(1);
    check_eq("drain3", 32'(io_evt_payload), 32'hB);
    tick(1);
    check_eq("drain4_v", 32'(io_evt_valid),   32'h1);
    check_eq("drain4",   32'(io_evt_payload), 32'h4);
    tick(1);
    check_eq("drain_empty",  32'(io_evt_valid), 32'h0);
    check_eq("ovf_sticky",   32'(io_overflow),  32'h1);
    io_evt_ready = 1'b0;

    // Reset with three releases queued; held btn0 re-emits its press
    io_btns = 7'b0000000;
    tick(14);
    check_eq("mid_valid", 32'(io_evt_valid),   32'h1);
    check_eq("mid_head",  32'(io_evt_payload), 32'h1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_eq("mid_rst_valid",    32'(io_evt_valid),   32'h0);
    check_eq("mid_rst_state",    32'(io_state),       32'h0);
    check_eq("mid_rst_overflow", 32'(io_overflow),    32'h0);
    check_eq("mid_rst_pulses",   32'(io_pressed | io_released), 32'h0);
    check_eq("mid_rst_payload",  32'(io_evt_payload), 32'h0);
    wait_pulse(0, 1'b0, 20, n);
    check_eq("held_latency", 32'(n), 32'd10);
    tick(2);
    check_eq("held_valid",   32'(io_evt_valid),   32'h1);
    check_eq("held_payload", 32'(io_evt_payload), 32'h8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
